// File: rtl/text_pkg.sv
// Shared constants and types for the character frame buffer.
package text_pkg;

  localparam int         CELLS          = 256;
  localparam logic [7:0] CLEAR_CHAR_DEF = 8'h20;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_ram.sv
// 256x8 text RAM: one write port, one registered read-first read port.
// Only the read register is reset; the array itself is left unreset so it
// maps onto block or distributed RAM.
module text_ram
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] ram_q [CELLS];
  logic [7:0] rdata_q;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) ram_q[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to the same cell returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= 8'h00;
    else        rdata_q <= ram_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_buffer.sv
// Character frame buffer: byte-stream decode, write cursor and clear sequencer
// in front of the text RAM that the renderer reads.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | writing CLEAR_CHAR to cell clr_cnt, one cell per cycle
// ST_IDLE  | accepting bytes; printables written at the cursor
module text_buffer
  import text_pkg::*;
#(
  parameter int         COLS       = 32,
  parameter logic [7:0] CLEAR_CHAR = CLEAR_CHAR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] addr,
  output logic [7:0] mem,
  output logic       ramBusy,
  output logic [7:0] cursor
);

  localparam logic [7:0] ROW_MASK = 8'(COLS - 1);
  localparam logic [7:0] ROW_STEP = 8'(COLS);

  state_e     state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic [7:0] cursor_q, cursor_d;

  logic       ram_we;
  logic [7:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] bs_addr;

  // State, clear counter and cursor registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= 8'h00;
      cursor_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cursor_q  <= cursor_d;
    end
  end

  // Backspace at cell 0 stays at cell 0 but still blanks it.
  assign bs_addr = (cursor_q == 8'h00) ? 8'h00 : cursor_q - 8'd1;

  // Next-state, cursor movement and RAM write decode.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cursor_d  = cursor_q;
    ram_we    = 1'b0;
    ram_waddr = cursor_q;
    ram_wdata = in_data;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = CLEAR_CHAR;
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'hFF) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            ram_we    = 1'b1;
            ram_waddr = cursor_q;
            ram_wdata = in_data;
            cursor_d  = cursor_q + 8'd1;
          end else begin
            case (in_data)
              CH_CR, CH_LF: cursor_d = (cursor_q & ~ROW_MASK) + ROW_STEP;
              CH_BS: begin
                ram_we    = 1'b1;
                ram_waddr = bs_addr;
                ram_wdata = CLEAR_CHAR;
                cursor_d  = bs_addr;
              end
              CH_FF: begin
                cursor_d  = 8'h00;
                clr_cnt_d = 8'h00;
                state_d   = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  text_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr),
    .rdata (mem)
  );

  // Handshake and busy flags come straight from the state register.
  assign in_ready = (state_q == ST_IDLE);
  assign ramBusy  = (state_q == ST_CLEAR);
  assign cursor   = cursor_q;

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed scenarios followed by random byte traffic,
// checked against a byte-level reference model through a scoreboard queue.
module tb_text_buffer;

  localparam int         COLS = 32;
  localparam logic [7:0] CC   = 8'h20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] addr = 8'h00;
  logic [7:0] mem;
  logic       ramBusy;
  logic [7:0] cursor;

  text_buffer #(.COLS(COLS), .CLEAR_CHAR(CC)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr     (addr),
    .mem      (mem),
    .ramBusy  (ramBusy),
    .cursor   (cursor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mem;
    bit         chk_mem;
    logic [7:0] cur;
    bit         rdy;
    bit         busy;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: screen contents, which cells are defined, cursor, clear progress.
  logic [7:0] m_ram [256];
  bit         m_known [256];
  int         m_cursor;
  bit         m_clear;
  int         m_cnt;

  bit rd_req = 1'b0;
  bit rd_pipe;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model.
  task automatic model_edge(input bit send, input logic [7:0] d);
    if (m_clear) begin
      m_ram[m_cnt]   = CC;
      m_known[m_cnt] = 1'b1;
      if (m_cnt == 255) m_clear = 1'b0;
      m_cnt = (m_cnt + 1) % 256;
    end else if (send) begin
      if (d >= 8'h20 && d <= 8'h7E) begin
        m_ram[m_cursor]   = d;
        m_known[m_cursor] = 1'b1;
        m_cursor = (m_cursor + 1) % 256;
      end else if (d == 8'h0D || d == 8'h0A) begin
        m_cursor = (((m_cursor / COLS) + 1) * COLS) % 256;
      end else if (d == 8'h08) begin
        if (m_cursor > 0) m_cursor = m_cursor - 1;
        m_ram[m_cursor]   = CC;
        m_known[m_cursor] = 1'b1;
      end else if (d == 8'h0C) begin
        m_cursor = 0;
        m_cnt    = 0;
        m_clear  = 1'b1;
      end
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show after the edge.
  task automatic step(input bit send, input logic [7:0] d, input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    in_valid = send;
    in_data  = d;
    addr     = a;
    rd_req   = 1'b1;
    e.chk_mem = m_known[a];
    e.mem     = m_ram[a];
    model_edge(send, d);
    e.cur  = 8'(m_cursor);
    e.rdy  = !m_clear;
    e.busy = m_clear;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'($urandom_range(0, 255)));
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    rd_req   = 1'b0;
    #1;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);
    chk("rst_ramBusy", {7'b0, ramBusy}, 8'h01);
    chk("rst_mem", mem, 8'h00);
    chk("rst_cursor", cursor, 8'h00);
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_cursor = 0;
    m_cnt    = 0;
    m_clear  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 199);
    if (r < 140) return 8'($urandom_range(32, 126));
    if (r < 156) return (r[0]) ? 8'h0D : 8'h0A;
    if (r < 174) return 8'h08;
    if (r < 176) return 8'h0C;
    if (r < 188) return 8'($urandom_range(128, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  // Result pipeline: a request driven before edge N is visible after edge N.
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_pipe <= 1'b0;
    else        rd_pipe <= rd_req;
  end

  // Monitor: compare DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (rd_pipe) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow: got no expectation required one at %0t", $time);
      end else begin
        me = sb.pop_front();
        if (me.chk_mem) chk("mem", mem, me.mem);
        chk("cursor", cursor, me.cur);
        chk("in_ready", {7'b0, in_ready}, {7'b0, me.rdy});
        chk("ramBusy", {7'b0, ramBusy}, {7'b0, me.busy});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_ram[i]   = 8'h00;
      m_known[i] = 1'b0;
    end
    m_cursor = 0;
    m_cnt    = 0;
    m_clear  = 1'b1;

    // Power-up clear, then spot reads.
    do_reset();
    idle(256);
    step(1'b0, 8'h00, 8'd0);
    step(1'b0, 8'h00, 8'd128);
    step(1'b0, 8'h00, 8'd255);

    // "AB", collision read of cell 1 while B is written, then read-after-write.
    send(8'h41);
    step(1'b1, 8'h42, 8'd1);
    step(1'b0, 8'h00, 8'd1);
    step(1'b0, 8'h00, 8'd0);

    // Backspace from 2, then down to 0, then at 0.
    send(8'h08);
    step(1'b0, 8'h00, 8'd1);
    send(8'h08);
    send(8'h41);
    send(8'h08);
    step(1'b1, 8'h08, 8'd0);
    step(1'b0, 8'h00, 8'd0);

    // LF from 37, CR from 230.
    for (int i = 0; i < 37; i++) send(8'($urandom_range(32, 126)));
    send(8'h0A);
    for (int i = 0; i < 166; i++) send(8'($urandom_range(32, 126)));
    send(8'h0D);

    // Fill the whole screen, wrap, and overwrite cell 0 with a collision read.
    for (int i = 0; i < 256; i++) send(8'($urandom_range(33, 126)));
    step(1'b1, 8'h5A, 8'd0);
    step(1'b0, 8'h00, 8'd0);

    // Mid-stream form feed, source keeps pushing while the clear runs.
    send(8'h61);
    send(8'h62);
    send(8'h0C);
    for (int i = 0; i < 256; i++) step(1'b1, 8'h63, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 256; i++) step(1'b0, 8'h00, 8'(i));

    // Reset partway through a clear restarts a full clear.
    send(8'h0C);
    idle(100);
    do_reset();
    idle(256);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 8'($urandom_range(0, 255)));

    // Random traffic with gaps and random read addresses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(rand_byte());
    end
    idle(300);

    @(negedge clk);
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
# text_buffer

Character frame buffer that feeds the VGA text renderer. It accepts a byte stream (typically from the UART receiver) over a valid/ready handshake and interprets printable characters and a small set of control codes. It maintains a write cursor and stores characters in a 256-cell text RAM. A registered read port serves the renderer's `addr`/`mem` fetches, and `ramBusy` is asserted while the buffer is being cleared.

## Interface
- `COLS`, default 32: characters per row; power of two; rows = 256/COLS (8 at default).
- `CLEAR_CHAR`, default 8'h20: fill value written by a clear.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  incoming character byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a byte this cycle.
- `addr`  in  8  renderer read address (cell index = row*COLS + col).
- `mem`  out  8  registered read data for `addr`.
- `ramBusy`  out  1  clear in progress; RAM contents are not stable.
- `cursor`  out  8  current write cell index.

## Operation
- FSM has two states, CLEAR and IDLE. Reset forces CLEAR with the clear counter at 0 and `cursor` at 0.
- CLEAR:
  - Writes `CLEAR_CHAR` to cell `clr_cnt` each cycle; `clr_cnt` runs 0..255.
  - After the write to cell 255, moves to IDLE.
  - `ramBusy`=1 and `in_ready`=0 throughout.
- IDLE: `in_ready`=1 and `ramBusy`=0. A byte is accepted when `in_valid` && `in_ready`; at most one byte per cycle. Handling by value:
  - Printable (8'h20..8'h7E): write to `cursor`, then `cursor`+1, wrapping mod 256 (cell 255 → 0).
  - CR 8'h0D or LF 8'h0A: no write; `cursor` moves to the start of the next row (`cursor` rounded down to a multiple of COLS, plus COLS, mod 256). The last row wraps to cell 0.
  - BS 8'h08: if `cursor`>0, decrement it and write `CLEAR_CHAR` to the new `cursor`. If `cursor`=0, write `CLEAR_CHAR` to cell 0 and `cursor` stays 0.
  - FF 8'h0C: `cursor` goes to 0, `clr_cnt` goes to 0, next state is CLEAR.
  - Any other byte: consumed with no effect.
- Read port: `mem` <= RAM[`addr`] every cycle, in every state.
- Read/write collision on the same cell in the same cycle is read-first: `mem` returns the old value.
- There is no scrolling; text overwrites from cell 0 after a wrap.

## Timing
- Reset values: `in_ready`=0, `ramBusy`=1, `mem`=8'h00, `cursor`=0. All are registered outputs.
- Power-up clear:
  - Starts on the first clock edge after `reset` deasserts.
  - Lasts exactly 256 cycles.
  - `in_ready` rises, and `ramBusy` falls, on the edge after the write to cell 255.
- Read latency: 1 cycle, `addr` sampled at edge N and `mem` valid after edge N.
- Write latency: a byte accepted at edge N is in the RAM, and `cursor` is updated, after edge N. A read of that cell issued at edge N+1 returns the new byte.
- FF accepted at edge N:
  - `in_ready`=0 and `ramBusy`=1 after edge N.
  - Clear writes occur at edges N+1..N+256.
  - IDLE after edge N+256.
- `reset` asserted mid-clear or mid-stream: all state returns to reset values immediately. RAM contents are undefined until the following clear completes.
- `in_valid` held while `in_ready`=0: nothing is consumed. The source must hold `in_data` stable.

## Structure
- Shared package `text_pkg` holds:
  - `CELLS`=256 and the default `CLEAR_CHAR`.
  - Control-code constants: `CH_BS` 8'h08, `CH_LF` 8'h0A, `CH_FF` 8'h0C, `CH_CR` 8'h0D.
  - Printable range bounds 8'h20/8'h7E.
  - The FSM state enum (CLEAR, IDLE).
- Sub-module `text_ram`: 256x8 synchronous RAM with one write port and one independent registered read port, read-first. It must infer block or distributed RAM with no reset on the array.
- `text_buffer` contains the FSM, cursor logic, clear counter, and byte decode.

## Test plan
- Reset, then release → `ramBusy`=1 and `in_ready`=0 for exactly 256 cycles. Afterwards, reading `addr` 0, 128 and 255 returns 8'h20.
- Send "AB" (8'h41, 8'h42) → cells 0 and 1 hold 8'h41 and 8'h42, and `cursor`=2. A read of cell 1 one cycle after its write returns 8'h42.
- At `cursor`=37 (row 1, col 5) send LF → `cursor`=64. At `cursor`=230 send CR → `cursor`=0.
- Backspace:
  - With `cursor`=2, send BS → `cursor`=1 and cell 1 = 8'h20.
  - With `cursor`=0, send BS → `cursor`=0 and cell 0 = 8'h20.
- Fill 256 printables → `cursor` wraps to 0. The 257th byte 8'h5A overwrites cell 0. A read of cell 0 in the same cycle as the write returns the old byte.
- Mid-stream FF → `in_ready` drops the next cycle, `ramBusy` is high for 256 cycles, and all cells read 8'h20 afterwards. Asserting `reset` at clear cycle 100 restarts a full 256-cycle clear after release.
